// File: rtl/serial_adder_ctrl_if.sv
// Bus between the serial adder sequencer, its requester and the 1-bit full-adder cell.
// The slave modport is the sequencer's view. The master modport is the requester/cell view.
interface serial_adder_ctrl_if #(
   parameter int unsigned NUM_BITS = 8
);
   logic                start;
   logic [NUM_BITS-1:0] a_in;
   logic [NUM_BITS-1:0] b_in;
   logic                carry_in;
   logic                bit_a;
   logic                bit_b;
   logic                bit_cin;
   logic                bit_sum;
   logic                bit_cout;
   logic                busy;
   logic                done;
   logic [NUM_BITS-1:0] sum_out;
   logic                carry_out;

   modport slave (
      input  start, a_in, b_in, carry_in, bit_sum, bit_cout,
      output bit_a, bit_b, bit_cin, busy, done, sum_out, carry_out
   );

   modport master (
      output start, a_in, b_in, carry_in, bit_sum, bit_cout,
      input  bit_a, bit_b, bit_cin, busy, done, sum_out, carry_out
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial NUM_BITS adder sequencer: feeds an external 1-bit full-adder cell LSB first,
// keeps the carry in a register between cycles and collects the sum bits into a result.
module serial_adder_ctrl #(
   parameter int unsigned NUM_BITS = 8
) (
   input logic               clk,
   input logic               rst,
   serial_adder_ctrl_if.slave bus
);
   localparam int unsigned CW = $clog2(NUM_BITS) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e              state_q;
   logic [NUM_BITS-1:0] a_sh_q;
   logic [NUM_BITS-1:0] b_sh_q;
   logic [NUM_BITS-1:0] s_sh_q;
   logic [NUM_BITS-1:0] s_sh_d;
   logic [NUM_BITS-1:0] sum_q;
   logic [CW-1:0]       cnt_q;
   logic                c_q;
   logic                cout_q;
   logic                done_q;
   logic                run;

   assign run    = (state_q == RUN);
   assign s_sh_d = {bus.bit_sum, s_sh_q[NUM_BITS-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         s_sh_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_sh_q  <= bus.a_in;
                  b_sh_q  <= bus.b_in;
                  c_q     <= bus.carry_in;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               // start is deliberately not looked at here so a running add cannot be disturbed
               a_sh_q <= a_sh_q >> 1;
               b_sh_q <= b_sh_q >> 1;
               s_sh_q <= s_sh_d;
               c_q    <= bus.bit_cout;
               cnt_q  <= cnt_q + CW'(1);
               if (cnt_q == CW'(NUM_BITS - 1)) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  sum_q   <= s_sh_d;
                  cout_q  <= bus.bit_cout;
               end
            end
            default: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.bit_a     = run & a_sh_q[0];
   assign bus.bit_b     = run & b_sh_q[0];
   assign bus.bit_cin   = run & c_q;
   assign bus.busy      = run;
   assign bus.done      = done_q;
   assign bus.sum_out   = sum_q;
   assign bus.carry_out = cout_q;

   a_cell_known : assert property (@(posedge clk) disable iff (rst)
      run |-> !$isunknown({bus.bit_sum, bus.bit_cout}))
      else $error("serial_adder_ctrl: bit_sum/bit_cout unknown during RUN");
endmodule
